// File: rtl/button_debounce_param_pkg.sv
// Shared debounce definitions: per-channel FSM state encoding and counter sizing.
package debounce_pkg;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_PRESS_CHK = 2'd1,
      ST_HELD      = 2'd2,
      ST_REL_CHK   = 2'd3
   } db_state_e;

   // One counter width covers both the stability window and the repeat intervals.
   function automatic int cnt_width(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      m = (m > c) ? m : c;
      return $clog2(m + 1);
   endfunction

endpackage

// File: rtl/button_debounce_param_channel.sv
// One button channel: 2-FF synchroniser, stability-window FSM, level/strobe outputs.
// Auto-repeat pulses are built only when DEBOUNCE_AUTOREPEAT_EN is defined.
module debounce_channel
   import debounce_pkg::*;
#(
   parameter int STABLE_CYCLES = 50000,
   parameter int ACTIVE_LOW    = 1,
   parameter int REPEAT_DELAY  = 25000000,
   parameter int REPEAT_PERIOD = 5000000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn_raw,
   output logic btn_level,
   output logic btn_press,
   output logic btn_release,
   output logic btn_repeat
);

   localparam int             CNT_W    = cnt_width(STABLE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD);
   localparam logic           RAW_REL  = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

   logic             raw_meta_q, raw_sync_q;
   logic             btn_s;
   db_state_e        state_q;
   logic [CNT_W-1:0] cnt_q;
   logic             level_q, press_q, release_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         raw_meta_q <= RAW_REL;
         raw_sync_q <= RAW_REL;
      end else begin
         raw_meta_q <= btn_raw;
         raw_sync_q <= raw_meta_q;
      end
   end

   assign btn_s = raw_sync_q ^ RAW_REL;

   // Entering a check state loads 1: the cycle that triggered the exit already agrees.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         level_q   <= 1'b0;
         press_q   <= 1'b0;
         release_q <= 1'b0;
      end else begin
         press_q   <= 1'b0;
         release_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (btn_s) begin
                  state_q <= ST_PRESS_CHK;
                  cnt_q   <= CNT_ONE;
               end
            end
            ST_PRESS_CHK: begin
               if (!btn_s) begin
                  state_q <= ST_IDLE;
                  cnt_q   <= '0;
               end else if (cnt_q == CNT_LAST) begin
                  state_q <= ST_HELD;
                  cnt_q   <= '0;
                  press_q <= 1'b1;
                  level_q <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + CNT_ONE;
               end
            end
            ST_HELD: begin
               if (!btn_s) begin
                  state_q <= ST_REL_CHK;
                  cnt_q   <= CNT_ONE;
               end
            end
            ST_REL_CHK: begin
               if (btn_s) begin
                  state_q <= ST_HELD;
                  cnt_q   <= '0;
               end else if (cnt_q == CNT_LAST) begin
                  state_q   <= ST_IDLE;
                  cnt_q     <= '0;
                  release_q <= 1'b1;
                  level_q   <= 1'b0;
               end else begin
                  cnt_q <= cnt_q + CNT_ONE;
               end
            end
            default: begin
               state_q <= ST_IDLE;
               cnt_q   <= '0;
            end
         endcase
      end
   end

   assign btn_level   = level_q;
   assign btn_press   = press_q;
   assign btn_release = release_q;

`ifdef DEBOUNCE_AUTOREPEAT_EN
   localparam logic [CNT_W-1:0] REP_FIRST = CNT_W'(REPEAT_DELAY - 1);
   localparam logic [CNT_W-1:0] REP_NEXT  = CNT_W'(REPEAT_PERIOD - 1);

   logic [CNT_W-1:0] rep_cnt_q;
   logic             rep_armed_q, rep_q;
   logic             rep_run;

   // Counting stops on the same edge HELD is left, so a release never overlaps a repeat.
   assign rep_run = (state_q == ST_HELD) && btn_s;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rep_cnt_q   <= '0;
         rep_armed_q <= 1'b0;
         rep_q       <= 1'b0;
      end else begin
         rep_q <= 1'b0;
         if (!rep_run) begin
            rep_cnt_q   <= '0;
            rep_armed_q <= 1'b0;
         end else if (rep_cnt_q == (rep_armed_q ? REP_NEXT : REP_FIRST)) begin
            rep_cnt_q   <= '0;
            rep_armed_q <= 1'b1;
            rep_q       <= 1'b1;
         end else begin
            rep_cnt_q <= rep_cnt_q + CNT_ONE;
         end
      end
   end

   assign btn_repeat = rep_q;
`else
   assign btn_repeat = 1'b0;
`endif

endmodule

// File: rtl/button_debounce_param.sv
// Multi-channel push-button debouncer: WIDTH independent debounce_channel copies.
// Define DEBOUNCE_AUTOREPEAT_EN to enable auto-repeat pulses on btn_repeat.
module button_debounce_param
   import debounce_pkg::*;
#(
   parameter int WIDTH         = 2,
   parameter int STABLE_CYCLES = 50000,
   parameter int ACTIVE_LOW    = 1,
   parameter int REPEAT_DELAY  = 25000000,
   parameter int REPEAT_PERIOD = 5000000
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] btn_raw,
   output logic [WIDTH-1:0] btn_level,
   output logic [WIDTH-1:0] btn_press,
   output logic [WIDTH-1:0] btn_release,
   output logic [WIDTH-1:0] btn_repeat
);

   for (genvar i = 0; i < WIDTH; i++) begin : g_ch
      debounce_channel #(
         .STABLE_CYCLES (STABLE_CYCLES),
         .ACTIVE_LOW    (ACTIVE_LOW),
         .REPEAT_DELAY  (REPEAT_DELAY),
         .REPEAT_PERIOD (REPEAT_PERIOD)
      ) u_ch (
         .clk         (clk),
         .rst_n       (rst_n),
         .btn_raw     (btn_raw[i]),
         .btn_level   (btn_level[i]),
         .btn_press   (btn_press[i]),
         .btn_release (btn_release[i]),
         .btn_repeat  (btn_repeat[i])
      );
   end

endmodule

// File: tb/tb_button_debounce_param.sv
// Scoreboard bench for button_debounce_param: expected strobes are queued by the
// stimulus with their cycle number; a negedge monitor pops and compares each strobe.
module tb_button_debounce_param;

   localparam int EV_PRESS = 0;
   localparam int EV_REL   = 1;
   localparam int EV_REP   = 2;

   typedef struct {
      int cyc;
      int ch;
      int kind;
   } ev_t;

   logic       clk;
   logic       rst_n;
   logic [1:0] btn_raw;
   logic [1:0] btn_level, btn_press, btn_release, btn_repeat;

   ev_t exp_q[$];
   int  cyc      = 0;
   int  vectors  = 0;
   int  errors   = 0;

   button_debounce_param #(
      .WIDTH         (2),
      .STABLE_CYCLES (4),
      .ACTIVE_LOW    (1),
      .REPEAT_DELAY  (8),
      .REPEAT_PERIOD (3)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .btn_raw     (btn_raw),
      .btn_level   (btn_level),
      .btn_press   (btn_press),
      .btn_release (btn_release),
      .btn_repeat  (btn_repeat)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic string kname(input int k);
      return (k == EV_PRESS) ? "press" : (k == EV_REL) ? "release" : "repeat";
   endfunction

   // Monitor: every asserted strobe must match the head of the expectation queue.
   always @(negedge clk) begin : mon
      logic s;
      ev_t  e;
      for (int c = 0; c < 2; c++) begin
         for (int k = 0; k < 3; k++) begin
            s = (k == EV_PRESS) ? btn_press[c] : (k == EV_REL) ? btn_release[c] : btn_repeat[c];
            if (s === 1'b1) begin
               vectors++;
               if (exp_q.size() == 0) begin
                  errors++;
                  $display("FAIL unexpected_strobe: got %s ch%0d at cycle %0d, expected none",
                           kname(k), c, cyc);
               end else begin
                  e = exp_q.pop_front();
                  if (e.cyc != cyc || e.ch != c || e.kind != k) begin
                     errors++;
                     $display("FAIL strobe_match: got %s ch%0d at cycle %0d, expected %s ch%0d at cycle %0d",
                              kname(k), c, cyc, kname(e.kind), e.ch, e.cyc);
                  end
               end
            end
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic expect_ev(input int cy, input int ch, input int kind);
      ev_t e;
      e.cyc  = cy;
      e.ch   = ch;
      e.kind = kind;
      exp_q.push_back(e);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
      end
   endtask

   initial begin
      int n;
      ev_t e;
      rst_n   = 1'b0;
      btn_raw = 2'b11;

      // Reset with keys released.
      tick(2);
      chk("reset_level",   btn_level,   0);
      chk("reset_press",   btn_press,   0);
      chk("reset_release", btn_release, 0);
      chk("reset_repeat",  btn_repeat,  0);
      rst_n = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick(1);
         chk("idle_level", btn_level, 0);
      end

      // Clean press then release on ch0.
      n = cyc;
      btn_raw[0] = 1'b0;
      expect_ev(n + 6, 0, EV_PRESS);
      tick(5);
      chk("press_early_level", btn_level[0], 0);
      tick(1);
      chk("press_level", btn_level[0], 1);
      n = cyc;
      btn_raw[0] = 1'b1;
      expect_ev(n + 6, 0, EV_REL);
      tick(5);
      chk("release_early_level", btn_level[0], 1);
      tick(1);
      chk("release_level", btn_level[0], 0);
      tick(4);

      // Bounce: low 3, high 1, then held low.
      btn_raw[0] = 1'b0;
      tick(3);
      btn_raw[0] = 1'b1;
      tick(1);
      btn_raw[0] = 1'b0;
      n = cyc;
      expect_ev(n + 6, 0, EV_PRESS);
      tick(5);
      chk("bounce_early_level", btn_level[0], 0);
      tick(1);
      chk("bounce_level", btn_level[0], 1);

      // Release ch0 and press ch1 on the same cycle.
      n = cyc;
      btn_raw = 2'b01;
      expect_ev(n + 6, 0, EV_REL);
      expect_ev(n + 6, 1, EV_PRESS);
      tick(6);
      chk("swap_level", btn_level, 2'b10);

      // Hold ch1 for repeats, release before the fourth one would fire.
      n = cyc;
`ifdef DEBOUNCE_AUTOREPEAT_EN
      expect_ev(n + 8,  1, EV_REP);
      expect_ev(n + 11, 1, EV_REP);
      expect_ev(n + 14, 1, EV_REP);
`endif
      for (int i = 0; i < 14; i++) begin
         tick(1);
`ifndef DEBOUNCE_AUTOREPEAT_EN
         chk("repeat_off", btn_repeat, 0);
`endif
      end
      n = cyc;
      btn_raw[1] = 1'b1;
      expect_ev(n + 6, 1, EV_REL);
      tick(6);
      chk("hold_release_level", btn_level, 2'b00);
      tick(10);

      // Reset pulse while ch0 is mid press-check.
      n = cyc;
      btn_raw[0] = 1'b0;
      tick(4);
      rst_n = 1'b0;
      tick(1);
      chk("midreset_level", btn_level, 0);
      rst_n = 1'b1;
      n = cyc;
      expect_ev(n + 6, 0, EV_PRESS);
      tick(5);
      chk("midreset_early_level", btn_level[0], 0);
      tick(1);
      chk("midreset_level_after", btn_level[0], 1);
      n = cyc;
      btn_raw[0] = 1'b1;
      expect_ev(n + 6, 0, EV_REL);
      tick(6);
      chk("final_level", btn_level, 0);
      tick(5);

      chk("queue_drained", exp_q.size(), 0);
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         errors++;
         $display("FAIL missing_strobe: got nothing, expected %s ch%0d at cycle %0d",
                  kname(e.kind), e.ch, e.cyc);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
